// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate cache controller with zero-latency hits.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
//
// state | meaning
// IDLE  | accept requests; hits and errors complete combinationally
// WB    | write dirty victim line back to memory, one word per ack
// FILL  | read requested line from memory, one word per ack
// RESP  | perform the held access on the freshly filled line
module dcache_ctrl #(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        cache_hit,
    output logic        err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_BITS = 15 - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t                  state, next;
    logic [LINES-1:0]        valid, dirty;
    logic [TAG_BITS-1:0]     tags  [LINES];
    logic [15:0]             words [LINES*WORDS];
    logic [OFFSET_BITS-1:0]  cnt;

    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   idx;
    logic [OFFSET_BITS-1:0]  off;
    logic                    illegal, hit, last, do_access;

    assign req_tag = addr[15 -: TAG_BITS];
    assign idx     = addr[OFFSET_BITS+1 +: INDEX_BITS];
    assign off     = addr[1 +: OFFSET_BITS];
    assign illegal = (rd && wr) || ((rd || wr) && addr[0]);
    assign hit     = valid[idx] && (tags[idx] == req_tag);
    assign last    = &cnt;

    always_comb begin
        next      = state;
        done      = 1'b0;
        stall     = 1'b0;
        cache_hit = 1'b0;
        err       = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        data_out  = '0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (illegal) begin
                    err  = 1'b1;
                    done = 1'b1;
                end else if (rd || wr) begin
                    if (hit) begin
                        done      = 1'b1;
                        cache_hit = 1'b1;
                        do_access = 1'b1;
                    end else begin
                        stall = 1'b1;
                        next  = (valid[idx] && dirty[idx]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                stall     = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {tags[idx], idx, cnt, 1'b0};
                mem_wdata = words[{idx, cnt}];
                if (mem_ack && last) next = FILL;
            end
            FILL: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {req_tag, idx, cnt, 1'b0};
                if (mem_ack && last) next = RESP;
            end
            RESP: begin
                done      = 1'b1;
                do_access = 1'b1;
                next      = IDLE;
            end
            default: next = IDLE;
        endcase
        if (do_access && rd && !wr) data_out = words[{idx, off}];
    end

    // The line is invalidated before its words are overwritten, so an aborted fill never leaves it valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
            cnt   <= '0;
        end else begin
            state <= next;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (next == FILL) valid[idx] <= 1'b0;
                end
                WB: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            dirty[idx] <= 1'b0;
                            valid[idx] <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        words[{idx, cnt}] <= mem_rdata;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            valid[idx] <= 1'b1;
                            dirty[idx] <= 1'b0;
                            tags[idx]  <= req_tag;
                        end
                    end
                end
                default: ;
            endcase
            if (do_access && wr && !rd) begin
                words[{idx, off}] <= data_in;
                dirty[idx]        <= 1'b1;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (done && cache_hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (state == IDLE && (next == WB || next == FILL) && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a one-cycle-ack memory model logs every word transfer.
// Backing memory word at byte address A initially holds A ^ 16'hC3C3.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst, rd, wr;
    logic [15:0] addr, data_in, data_out;
    logic        done, stall, cache_hit, err;
    logic        mem_rd, mem_wr, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int n_vec = 0;
    int n_miscompare = 0;
    int cyc, start;

    logic [15:0] mem [32768];
    logic [15:0] log_addr [$];
    logic        log_we   [$];
    logic [15:0] log_data [$];

    dcache_ctrl #(.INDEX_BITS(3), .OFFSET_BITS(2)) dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .done(done), .stall(stall), .cache_hit(cache_hit), .err(err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[15:1]];

    initial begin
        mem_ack = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            logic [15:0] a;
            a = 16'(i * 2);
            mem[i] = a ^ 16'hC3C3;
        end
        forever begin
            @(posedge clk);
            if (mem_ack && (mem_rd || mem_wr)) begin
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_wr);
                log_data.push_back(mem_wr ? mem_wdata : mem_rdata);
                if (mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
            end
            mem_ack <= (mem_rd || mem_wr) && !mem_ack;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        rd = r;
        wr = w;
        addr = a;
        data_in = d;
        #1;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (c < 80) begin
            @(negedge clk);
            c++;
            chk("mem_excl", {31'd0, mem_rd && mem_wr}, 32'd0);
            if (done) break;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_log(input int s, input logic [15:0] base, input logic we, input string tag);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] ea;
            ea = base + 16'(2 * k);
            chk({tag, "_addr"}, {16'd0, log_addr[s+k]}, {16'd0, ea});
            chk({tag, "_we"}, {31'd0, log_we[s+k]}, {31'd0, we});
        end
    endtask

    initial begin
        rst = 1'b1;
        rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_hit", {31'd0, cache_hit}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_memrd", {31'd0, mem_rd}, 0);
        chk("rst_memwr", {31'd0, mem_wr}, 0);
        chk("rst_dout", {16'd0, data_out}, 0);
        rst = 1'b0;
        @(negedge clk);

        // cold read miss
        start = log_addr.size();
        drive(1, 0, 16'h0010, 0);
        chk("m0_stall", {31'd0, stall}, 1);
        chk("m0_done", {31'd0, done}, 0);
        wait_done(cyc);
        chk("m0_lat", cyc, 9);
        chk("m0_hit", {31'd0, cache_hit}, 0);
        chk("m0_dout", {16'd0, data_out}, 32'hC3D3);
        chk("m0_nlog", log_addr.size(), start + 4);
        check_log(start, 16'h0010, 0, "m0");
        chk("m0_rdata0", {16'd0, log_data[start]}, 32'hC3D3);
        drive(0, 0, 0, 0);
        @(negedge clk);

        // hits
        drive(1, 0, 16'h0012, 0);
        chk("h0_done", {31'd0, done}, 1);
        chk("h0_hit", {31'd0, cache_hit}, 1);
        chk("h0_stall", {31'd0, stall}, 0);
        chk("h0_memrd", {31'd0, mem_rd}, 0);
        chk("h0_dout", {16'd0, data_out}, 32'hC3D1);
        @(negedge clk);
        drive(1, 0, 16'h0016, 0);
        chk("h1_dout", {16'd0, data_out}, 32'hC3D5);
        @(negedge clk);
        drive(0, 1, 16'h0010, 16'hBEEF);
        chk("w0_done", {31'd0, done}, 1);
        chk("w0_hit", {31'd0, cache_hit}, 1);
        @(negedge clk);
        drive(1, 0, 16'h0010, 0);
        chk("w0_rback", {16'd0, data_out}, 32'hBEEF);
        @(negedge clk);

        // dirty eviction
        start = log_addr.size();
        drive(1, 0, 16'h0050, 0);
        chk("m1_stall", {31'd0, stall}, 1);
        wait_done(cyc);
        chk("m1_lat", cyc, 17);
        chk("m1_hit", {31'd0, cache_hit}, 0);
        chk("m1_dout", {16'd0, data_out}, 32'hC393);
        chk("m1_nlog", log_addr.size(), start + 8);
        check_log(start, 16'h0010, 1, "wb");
        chk("wb_d0", {16'd0, log_data[start]}, 32'hBEEF);
        chk("wb_d1", {16'd0, log_data[start+1]}, 32'hC3D1);
        chk("wb_d3", {16'd0, log_data[start+3]}, 32'hC3D5);
        check_log(start + 4, 16'h0050, 0, "m1");
        drive(0, 0, 0, 0);
        @(negedge clk);

        // clean victim, written-back data must come back from memory
        start = log_addr.size();
        drive(1, 0, 16'h0010, 0);
        wait_done(cyc);
        chk("m2_lat", cyc, 9);
        chk("m2_dout", {16'd0, data_out}, 32'hBEEF);
        chk("m2_nlog", log_addr.size(), start + 4);
        drive(0, 0, 0, 0);
        @(negedge clk);

        // illegal requests
        start = log_addr.size();
        drive(1, 1, 16'h0010, 0);
        chk("e0_err", {31'd0, err}, 1);
        chk("e0_done", {31'd0, done}, 1);
        chk("e0_stall", {31'd0, stall}, 0);
        chk("e0_hit", {31'd0, cache_hit}, 0);
        @(negedge clk);
        drive(1, 0, 16'h0011, 0);
        chk("e1_err", {31'd0, err}, 1);
        chk("e1_done", {31'd0, done}, 1);
        chk("e1_memrd", {31'd0, mem_rd}, 0);
        @(negedge clk);
        drive(0, 1, 16'h0013, 16'h1234);
        chk("e2_err", {31'd0, err}, 1);
        chk("e2_memwr", {31'd0, mem_wr}, 0);
        @(negedge clk);
        drive(1, 0, 16'h0010, 0);
        chk("e3_err", {31'd0, err}, 0);
        chk("e3_hit", {31'd0, cache_hit}, 1);
        chk("e3_dout", {16'd0, data_out}, 32'hBEEF);
        chk("e_nlog", log_addr.size(), start);
        drive(0, 0, 0, 0);
        @(negedge clk);

        // reset during the second fill word
        drive(1, 0, 16'h0030, 0);
        repeat (3) @(negedge clk);
        chk("r_addr", {16'd0, mem_addr}, 32'h0032);
        chk("r_memrd", {31'd0, mem_rd}, 1);
        rst = 1'b1;
        rd = 1'b0;
        @(negedge clk);
        chk("r_memrd_off", {31'd0, mem_rd}, 0);
        chk("r_memwr_off", {31'd0, mem_wr}, 0);
        chk("r_stall_off", {31'd0, stall}, 0);
        rst = 1'b0;
        @(negedge clk);
        start = log_addr.size();
        drive(1, 0, 16'h0030, 0);
        chk("r1_stall", {31'd0, stall}, 1);
        wait_done(cyc);
        chk("r1_lat", cyc, 9);
        chk("r1_dout", {16'd0, data_out}, 32'hC3F3);
        chk("r1_nlog", log_addr.size(), start + 4);
        check_log(start, 16'h0030, 0, "r1");
        drive(0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 16'h0010, 0);
        chk("r2_stall", {31'd0, stall}, 1);
        chk("r2_done", {31'd0, done}, 0);
        wait_done(cyc);
        chk("r2_dout", {16'd0, data_out}, 32'hBEEF);
        drive(0, 0, 0, 0);
        @(negedge clk);

`ifdef DCACHE_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s_hit0", {16'd0, hit_count}, 0);
        chk("s_miss0", {16'd0, miss_count}, 0);
        drive(1, 0, 16'h0020, 0);
        wait_done(cyc);
        drive(0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 16'h0022, 0);
        repeat (3) @(negedge clk);
        drive(0, 0, 0, 0);
        chk("s_hit3", {16'd0, hit_count}, 3);
        chk("s_miss1", {16'd0, miss_count}, 1);
        drive(1, 0, 16'h0022, 0);
        repeat (65540) @(negedge clk);
        drive(0, 0, 0, 0);
        chk("s_hit_sat", {16'd0, hit_count}, 32'hFFFF);
        chk("s_miss_hold", {16'd0, miss_count}, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
